// File: rtl/dfm_mem_responder_pkg.sv
// Shared definitions for the DFM data-memory responder.
//   dfm_state_t     : responder FSM states (zero-fill, then serving)
//   ERR_OOR         : bit index of the out-of-range sticky flag
//   ERR_MISALIGNED  : bit index of the misaligned sticky flag
//   ERR_W           : width of the packed error-flag vector
package pkg_dfm_defs;

  typedef enum logic [0:0] {
    DFM_CLEAR,
    DFM_READY
  } dfm_state_t;

  localparam int ERR_OOR        = 0;
  localparam int ERR_MISALIGNED = 1;
  localparam int ERR_W          = 2;

endpackage

// File: rtl/dfm_mem_responder_if.sv
// CPU <-> data-memory bus.
//   dfm_req_addr  : byte address from the CPU
//   dfm_wr_en     : store strobe
//   dfm_wr_data   : store data
//   dfm_rd_data   : registered load data from the responder
//   dfm_ready     : responder is serving requests
// master = CPU side, slave = memory responder side.
interface dfm_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] dfm_req_addr;
  logic                  dfm_wr_en;
  logic [DATA_WIDTH-1:0] dfm_wr_data;
  logic [DATA_WIDTH-1:0] dfm_rd_data;
  logic                  dfm_ready;

  modport master (
    output dfm_req_addr,
    output dfm_wr_en,
    output dfm_wr_data,
    input  dfm_rd_data,
    input  dfm_ready
  );

  modport slave (
    input  dfm_req_addr,
    input  dfm_wr_en,
    input  dfm_wr_data,
    output dfm_rd_data,
    output dfm_ready
  );

endinterface

// File: rtl/dfm_mem_responder_ram_sp.sv
// Single-port, read-first synchronous RAM with a registered read output.
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset of the read register only
//   we       : write enable for mem[addr]
//   addr     : word index shared by read and write
//   wdata    : write data
//   rd_en    : 1 = load mem[addr] into rd_data, 0 = load zero
//   rd_data  : registered read data (old word on a same-address write)
module dfm_ram_sp #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register samples the pre-write word, giving read-first behaviour.
  // Zero-loading when rd_en is low lets the top force rd_data to 0 without
  // an extra output mux, so the output always comes from a reset register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/dfm_mem_responder.sv
// Data-memory responder for the CPU's dfm_* bus.
// Zero-fills the array after reset, then serves word loads (1-cycle latency)
// and stores, flagging out-of-range and misaligned accesses in sticky bits.
//   sys_clk         : clock, all logic on posedge
//   sys_rst         : synchronous active-high reset
//   bus             : dfm_* request/response bus (slave side)
//   err_clr         : clears both sticky error bits
//   err_oor         : sticky, an access had word index >= DEPTH
//   err_misaligned  : sticky, an access had addr[1:0] != 0
module dfm_mem_responder
  import pkg_dfm_defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int INIT_CLEAR = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  dfm_mem_responder_if.slave   bus,
  input  logic                 err_clr,
  output logic                 err_oor,
  output logic                 err_misaligned
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dfm_state_t            state;
  logic [IDX_W-1:0]      clr_idx;
  logic                  ready_q;
  logic [ERR_W-1:0]      err_q;

  logic [IDX_W-1:0]      cpu_idx;
  logic                  in_range;
  logic                  misaligned;
  logic                  serving;

  logic                  ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_rd_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Any address bit above the word-index field makes the access out of range.
  assign cpu_idx    = bus.dfm_req_addr[IDX_W+1:2];
  assign in_range   = (bus.dfm_req_addr >> (IDX_W + 2)) == '0;
  assign misaligned = bus.dfm_req_addr[1:0] != 2'b00;
  assign serving    = (state == DFM_READY);

  // The single RAM port belongs to the clear engine until READY, then to the
  // CPU. Writes are blocked during reset so a reset never disturbs contents.
  assign ram_we    = !sys_rst && (serving ? (bus.dfm_wr_en && in_range) : 1'b1);
  assign ram_addr  = serving ? cpu_idx : clr_idx;
  assign ram_wdata = serving ? bus.dfm_wr_data : '0;
  assign ram_rd_en = serving && in_range;

  dfm_ram_sp #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rd_en   (ram_rd_en),
    .rd_data (ram_rd_data)
  );

  // Zero-fill sequencer: one word per cycle, READY after the last word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= (INIT_CLEAR != 0) ? DFM_CLEAR : DFM_READY;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        DFM_CLEAR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == LAST_IDX) begin
            state   <= DFM_READY;
            ready_q <= 1'b1;
          end
        end
        DFM_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state <= DFM_CLEAR;
        end
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle beats err_clr.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q <= '0;
    end else begin
      if (serving && !in_range) begin
        err_q[ERR_OOR] <= 1'b1;
      end else if (err_clr) begin
        err_q[ERR_OOR] <= 1'b0;
      end

      if (serving && misaligned) begin
        err_q[ERR_MISALIGNED] <= 1'b1;
      end else if (err_clr) begin
        err_q[ERR_MISALIGNED] <= 1'b0;
      end
    end
  end

  assign bus.dfm_rd_data = ram_rd_data;
  assign bus.dfm_ready   = ready_q;
  assign err_oor         = err_q[ERR_OOR];
  assign err_misaligned  = err_q[ERR_MISALIGNED];

endmodule

// File: tb/tb_dfm_mem_responder.sv
// Self-checking bench for dfm_mem_responder (DEPTH=1024, INIT_CLEAR=1).
// Directed vector table for the load/store corner cases, randomized traffic
// against a word-array reference model, and reset/clear sequences.
module tb_dfm_mem_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic tb_clk = 1'b0;
  logic sys_rst;
  logic err_clr;
  logic err_oor;
  logic err_misaligned;

  int checks = 0;
  int errors = 0;

  // Reference model state: the word array and the expected outputs.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;
  logic        model_oor;
  logic        model_mis;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic        clr;
    logic [31:0] exp_rd;
    logic        exp_oor;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  dfm_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dfm_bus ();

  dfm_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .INIT_CLEAR (1)
  ) dut (
    .sys_clk        (tb_clk),
    .sys_rst        (sys_rst),
    .bus            (dfm_bus),
    .err_clr        (err_clr),
    .err_oor        (err_oor),
    .err_misaligned (err_misaligned)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_rd, input logic exp_oor,
                             input logic exp_mis, input logic exp_ready);
    checkValue({name, ".rd_data"}, dfm_bus.dfm_rd_data, exp_rd);
    checkValue({name, ".err_oor"}, {31'b0, err_oor}, {31'b0, exp_oor});
    checkValue({name, ".err_misaligned"}, {31'b0, err_misaligned}, {31'b0, exp_mis});
    checkValue({name, ".ready"}, {31'b0, dfm_bus.dfm_ready}, {31'b0, exp_ready});
  endtask

  task automatic driveInputs(input logic [31:0] addr, input logic we, input logic [31:0] data, input logic clr);
    dfm_bus.dfm_req_addr = addr;
    dfm_bus.dfm_wr_en    = we;
    dfm_bus.dfm_wr_data  = data;
    err_clr              = clr;
  endtask

  // Model of one serving cycle, stated in terms of byte addresses and words.
  task automatic modelStep(input logic [31:0] addr, input logic we, input logic [31:0] data, input logic clr);
    bit ok;
    int idx;
    ok  = addr < 32'(DEPTH * 4);
    idx = int'((addr / 4) % DEPTH);
    if (ok) begin
      model_rd = model_mem[idx];
      if (we) model_mem[idx] = data;
    end else begin
      model_rd = 32'h0;
    end
    if (!ok) model_oor = 1'b1;
    else if (clr) model_oor = 1'b0;
    if ((addr % 4) != 0) model_mis = 1'b1;
    else if (clr) model_mis = 1'b0;
  endtask

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_rd  = 32'h0;
    model_oor = 1'b0;
    model_mis = 1'b0;
  endtask

  // One READY-state cycle: drive, clock, settle, advance the model.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] data, input logic clr);
    driveInputs(addr, we, data, clr);
    @(posedge tb_clk);
    #1;
    modelStep(addr, we, data, clr);
  endtask

  task automatic doReset(input string name);
    sys_rst = 1'b1;
    driveInputs(32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge tb_clk);
    #1;
    checkOutput(name, 32'h0, 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b0;
  endtask

  // Runs clear cycles with hostile CPU traffic. With expect_ready the ready
  // latency after reset release is checked; otherwise ready must stay low.
  task automatic runClear(input int max_cycles, input bit expect_ready, input string name);
    int n = 0;
    int bad = 0;
    bit seen = 0;
    logic [31:0] addr;
    while (n < max_cycles && !seen) begin
      addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'hFFF));
      driveInputs(addr, 1'b1, $urandom | 32'h1, 1'($urandom_range(0, 1)));
      @(posedge tb_clk);
      #1;
      n++;
      if (dfm_bus.dfm_ready === 1'b1) seen = 1;
      else if (dfm_bus.dfm_rd_data !== 32'h0 || err_oor !== 1'b0 || err_misaligned !== 1'b0) bad++;
    end
    checkValue({name, ".quiet_during_clear"}, 32'(bad), 32'h0);
    if (expect_ready) begin
      checkValue({name, ".ready_latency"}, 32'(n), 32'(DEPTH));
      checkOutput({name, ".first_ready"}, 32'h0, 1'b0, 1'b0, 1'b1);
    end else begin
      checkValue({name, ".ready_low"}, {31'b0, seen}, 32'h0);
    end
    driveInputs(32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic sweepZero(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(32'(i * 4), 1'b0, 32'h0, 1'b0);
      if (dfm_bus.dfm_rd_data !== 32'h0) bad++;
    end
    checkValue({name, ".nonzero_words"}, 32'(bad), 32'h0);
  endtask

  task automatic addVec(input string name, input logic [31:0] addr, input logic we, input logic [31:0] data,
                        input logic clr, input logic [31:0] exp_rd, input logic exp_oor, input logic exp_mis);
    vec_t v;
    v.name = name; v.addr = addr; v.we = we; v.data = data; v.clr = clr;
    v.exp_rd = exp_rd; v.exp_oor = exp_oor; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] addr;

    // Directed vectors, applied to a freshly cleared array with clear flags.
    addVec("wr_deadbeef",   32'h10,   1, 32'hDEADBEEF, 0, 32'h0,        0, 0);
    addVec("rd_deadbeef",   32'h10,   0, 32'h0,        0, 32'hDEADBEEF, 0, 0);
    addVec("wr_11111111",   32'h20,   1, 32'h11111111, 0, 32'h0,        0, 0);
    addVec("collide_old",   32'h20,   1, 32'h22222222, 0, 32'h11111111, 0, 0);
    addVec("collide_new",   32'h20,   0, 32'h0,        0, 32'h22222222, 0, 0);
    addVec("oor_write",     32'h1000, 1, 32'hCAFEF00D, 0, 32'h0,        1, 0);
    addVec("oor_read",      32'h1000, 0, 32'h0,        0, 32'h0,        1, 0);
    addVec("mem0_intact",   32'h0,    0, 32'h0,        0, 32'h0,        1, 0);
    addVec("oor_clear",     32'h0,    0, 32'h0,        1, 32'h0,        0, 0);
    addVec("mis_write",     32'h6,    1, 32'h12345678, 0, 32'h0,        0, 1);
    addVec("mis_readback",  32'h4,    0, 32'h0,        0, 32'h12345678, 0, 1);
    addVec("mis_clr_race",  32'h7,    0, 32'h0,        1, 32'h12345678, 0, 1);
    addVec("mis_clear",     32'h4,    0, 32'h0,        1, 32'h12345678, 0, 0);
    addVec("rd_top_word",   32'hFFC,  0, 32'h0,        0, 32'h0,        0, 0);

    sys_rst = 1'b1;
    driveInputs(32'h0, 1'b0, 32'h0, 1'b0);

    doReset("reset1");
    runClear(2000, 1, "clear1");
    modelClear();
    sweepZero("sweep1");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].clr);
      checkOutput(vecs[i].name, vecs[i].exp_rd, vecs[i].exp_oor, vecs[i].exp_mis, 1'b1);
    end

    // Randomized traffic: a small word window for frequent collisions, plus
    // misaligned, just-out-of-range and arbitrary addresses.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'h1000 + 32'($urandom_range(0, 255));
        2:       addr = 32'($urandom_range(0, 63));
        default: addr = 32'($urandom_range(0, 15) * 4);
      endcase
      applyStimulus(addr, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0);
      checkOutput("random", model_rd, model_oor, model_mis, 1'b1);
    end

    // Reset in the middle of the clear restarts it from index 0.
    doReset("reset2");
    runClear(500, 0, "clear2_partial");
    doReset("reset3");
    runClear(2000, 1, "clear3");
    modelClear();
    sweepZero("sweep2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
